if_fetch_stage: RTL and testbench
=================================

// Module: if_fetch_stage
// PURPOSE
//  Instruction-fetch stage: owns the PC, issues requests on the SRAM-like inst bus and delivers {PC, Inst}
//  to the decode stage through a valid/ready handshake. It is the transmitter end of the fetch->decode link.
//  Supports redirect (taken branch/jump from EXE) and pipeline flush. Sits between inst RAM and decode.
// PARAMETERS
//  RESET_PC    32'h1c00_0000  PC of the first fetch after reset
//  BUF_DEPTH   2              fetch output buffer entries (power of 2, >=2)
// PORTS
//  clk            in   1   clock
//  reset          in   1   synchronous, active-high reset
//  inst_req       out  1   request valid to inst RAM
//  inst_addr      out  32  request address (word aligned)
//  inst_addr_ok   in   1   request accepted this cycle
//  inst_data_ok   in   1   read data returned this cycle
//  inst_rdata     in   32  read data
//  redirect_valid in   1   branch/jump taken, restart fetch
//  redirect_pc    in   32  redirect target
//  flush          in   1   kill all in-flight/buffered fetches; acts as redirect to redirect_pc
//  right_valid    out  1   {PC, Inst} valid to decode
//  right_ready    in   1   decode allowin
//  PC             out  32  PC of delivered instruction
//  Inst           out  32  delivered instruction word
//  excp_adef      out  1   fetch address misaligned (see CONFIGURATION)
// BEHAVIOUR
//  Reset: pc_q=RESET_PC, state=REQ, buffer empty, discard=0; inst_req=0, right_valid=0, PC=0, Inst=0, excp_adef=0
//    during the reset cycle.
//  Handshakes: decode consumes on right_valid&right_ready; RAM accepts on inst_req&inst_addr_ok.
//  At most one outstanding request. inst_addr=pc_q.
//  FSM:
//    REQ : inst_req=1 iff (buf_count + 0) < BUF_DEPTH (slot reserved for reply). addr_ok -> WAIT.
//    WAIT: inst_req=0. data_ok -> if discard: drop data, clear discard; else push {pc_q,rdata}, pc_q+=4; -> REQ.
//  Redirect/flush (same handling; flush has priority if both):
//    - buffer cleared same cycle; right_valid=0 the following cycle.
//    - REQ without addr_ok: pc_q<=redirect_pc, stay REQ.
//    - REQ with addr_ok: stale request in flight -> WAIT, discard=1, pc_q<=redirect_pc.
//    - WAIT without data_ok: discard=1, pc_q<=redirect_pc.
//    - WAIT with data_ok: data dropped, discard unchanged=0, pc_q<=redirect_pc, -> REQ.
//    - redirect in same cycle as a decode pop: pop still counts, entry is gone anyway.
//  Buffer: FIFO, push on accepted data_ok, pop on right_fire; simultaneous push+pop when full is legal only if
//    count<BUF_DEPTH was true at issue (guaranteed by issue rule). Pointers wrap mod BUF_DEPTH.
//  Latency: reset deassert -> inst_req in 1 cycle; data_ok -> right_valid next cycle (registered buffer output).
//  Throughput: one instruction per 2 cycles minimum with 1-cycle RAM (single outstanding).
//  pc_q arithmetic: 32-bit, wraps 0xFFFF_FFFC -> 0x0000_0000 silently.
//  Reset mid-transaction: all state back to reset values; a later data_ok for the killed request is ignored
//    (discard is NOT set; the RAM is reset with the core).
// CONFIGURATION
//  IF_ADEF_CHK_EN defined: if pc_q[1:0]!=0, no RAM request is issued; a pseudo entry {pc_q, 32'h0, adef=1}
//    is pushed instead and fetch stalls in REQ until redirect/flush. excp_adef follows the head entry.
//  Not defined: pc_q[1:0] forced to 0 on redirect; excp_adef tied 0; no extra buffer bit.
// STRUCTURE
//  if_pkg: RESET_PC_DEF, fetch_state_e {REQ, WAIT}, fetch_entry_t {pc[31:0], inst[31:0], adef}.
//  Sub-module if_fetch_buf: BUF_DEPTH-entry FIFO of fetch_entry_t with push/pop/clear, count, full/empty.
//  Top holds FSM, pc_q, discard flag, redirect muxing.
// TESTING
//  1 Reset release, RAM addr_ok=1, data_ok 1 cycle later, right_ready=1 -> PCs 1c000000,1c000004,1c000008 in order.
//  2 right_ready=0 for 10 cycles -> exactly 2 entries buffered, inst_req=0 when full; release -> drained in order.
//  3 Redirect to 1c000100 while WAIT (no data_ok) -> next data_ok dropped, next delivered PC=1c000100.
//  4 Redirect in same cycle as data_ok -> that data never appears; next request addr=redirect_pc, no extra drop.
//  5 flush with 2 buffered entries and right_ready=1 -> right_valid=0 next cycle, no stale PC ever delivered.
//  6 IF_ADEF_CHK_EN, redirect to 1c000102 -> no inst_req, entry PC=1c000102 excp_adef=1; without macro addr=1c000100.

Source files
------------

// File: rtl/if_pkg.sv
// Shared types and constants for the instruction-fetch stage.
// With IF_ADEF_CHK_EN defined each buffered entry carries a misaligned-fetch flag.
package if_pkg;

   localparam logic [31:0] RESET_PC_DEF = 32'h1c00_0000;

   typedef enum logic [0:0] {
      REQ  = 1'b0,
      WAIT = 1'b1
   } fetch_state_e;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] inst;
`ifdef IF_ADEF_CHK_EN
      logic        adef;
`endif
   } fetch_entry_t;

   function automatic logic [31:0] next_pc(input logic [31:0] pc);
      return pc + 32'd4;
   endfunction

endpackage

// File: rtl/if_fetch_buf.sv
// Fetch output FIFO of fetch_entry_t between the inst RAM reply and decode.
// DEPTH must be a power of two so the pointers wrap naturally.
module if_fetch_buf
   import if_pkg::*;
#(
   parameter int DEPTH = 2
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         clear,
   input  logic         push,
   input  fetch_entry_t push_entry,
   input  logic         pop,
   output fetch_entry_t head,
   output logic         full,
   output logic         empty
);

   localparam int AW = $clog2(DEPTH);

   fetch_entry_t  mem_r [DEPTH];
   logic [AW-1:0] wr_ptr_r;
   logic [AW-1:0] rd_ptr_r;
   logic [AW:0]   count_r;

   // Storage, pointers and occupancy; clear empties the FIFO ahead of any push/pop.
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_r <= '0;
         rd_ptr_r <= '0;
         count_r  <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            mem_r[i] <= '0;
         end
      end else if (clear) begin
         wr_ptr_r <= '0;
         rd_ptr_r <= '0;
         count_r  <= '0;
      end else begin
         if (push) begin
            mem_r[wr_ptr_r] <= push_entry;
            wr_ptr_r        <= wr_ptr_r + AW'(1);
         end
         if (pop) begin
            rd_ptr_r <= rd_ptr_r + AW'(1);
         end
         case ({push, pop})
            2'b10:   count_r <= count_r + (AW+1)'(1);
            2'b01:   count_r <= count_r - (AW+1)'(1);
            default: count_r <= count_r;
         endcase
      end
   end

   assign head  = mem_r[rd_ptr_r];
   assign full  = (count_r == (AW+1)'(DEPTH));
   assign empty = (count_r == (AW+1)'(0));

endmodule

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: owns the PC, talks to the SRAM-like inst bus, hands {PC, Inst} to decode.
// Optional IF_ADEF_CHK_EN: misaligned PCs produce an exception entry instead of a RAM request.
module if_fetch_stage
   import if_pkg::*;
#(
   parameter logic [31:0] RESET_PC  = RESET_PC_DEF,
   parameter int          BUF_DEPTH = 2
) (
   input  logic        clk,
   input  logic        reset,
   output logic        inst_req,
   output logic [31:0] inst_addr,
   input  logic        inst_addr_ok,
   input  logic        inst_data_ok,
   input  logic [31:0] inst_rdata,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   input  logic        flush,
   output logic        right_valid,
   input  logic        right_ready,
   output logic [31:0] PC,
   output logic [31:0] Inst,
   output logic        excp_adef
);

   fetch_state_e state_r;
   fetch_state_e state_nxt_s;
   logic [31:0]  pc_r;
   logic [31:0]  pc_nxt_s;
   logic         discard_r;
   logic         discard_nxt_s;

   logic         redir_s;
   logic [31:0]  redir_pc_s;
   logic         issue_s;
   logic         addr_fire_s;
   logic         right_fire_s;
   logic         push_s;
   fetch_entry_t push_entry_s;
   fetch_entry_t head_s;
   logic         full_s;
   logic         empty_s;

   // flush and redirect share the same target, so flush priority only matters for intent
   assign redir_s = flush | redirect_valid;

`ifdef IF_ADEF_CHK_EN
   logic adef_done_r;
   logic adef_done_nxt_s;
   logic misal_s;

   assign redir_pc_s = redirect_pc;
   assign misal_s    = (pc_r[1:0] != 2'b00);
   assign issue_s    = (state_r == REQ) & ~full_s & ~misal_s;
`else
   assign redir_pc_s = redirect_pc & 32'hFFFF_FFFC;
   assign issue_s    = (state_r == REQ) & ~full_s;
`endif

   assign inst_req     = issue_s & ~reset;
   assign inst_addr    = pc_r;
   assign addr_fire_s  = inst_req & inst_addr_ok;
   assign right_valid  = ~reset & ~empty_s;
   assign right_fire_s = right_valid & right_ready;
   assign PC           = reset ? 32'h0 : head_s.pc;
   assign Inst         = reset ? 32'h0 : head_s.inst;
`ifdef IF_ADEF_CHK_EN
   assign excp_adef    = right_valid & head_s.adef;
`else
   assign excp_adef    = 1'b0;
`endif

   // Next state, next PC, discard flag and buffer push decode.
   always_comb begin
      state_nxt_s       = state_r;
      pc_nxt_s          = pc_r;
      discard_nxt_s     = discard_r;
      push_s            = 1'b0;
      push_entry_s      = '0;
      push_entry_s.pc   = pc_r;
      push_entry_s.inst = inst_rdata;
`ifdef IF_ADEF_CHK_EN
      adef_done_nxt_s   = redir_s ? 1'b0 : adef_done_r;
`endif
      case (state_r)
         REQ: begin
            if (redir_s) begin
               pc_nxt_s = redir_pc_s;
               if (addr_fire_s) begin
                  // the request just accepted fetches the old path; drop its reply
                  state_nxt_s   = WAIT;
                  discard_nxt_s = 1'b1;
               end else begin
                  state_nxt_s = REQ;
               end
            end else if (addr_fire_s) begin
               state_nxt_s = WAIT;
            end else begin
               state_nxt_s = REQ;
`ifdef IF_ADEF_CHK_EN
               if (misal_s && !full_s && !adef_done_r) begin
                  push_s            = 1'b1;
                  push_entry_s.inst = 32'h0;
                  push_entry_s.adef = 1'b1;
                  adef_done_nxt_s   = 1'b1;
               end else begin
                  push_s = 1'b0;
               end
`endif
            end
         end
         WAIT: begin
            if (inst_data_ok) begin
               state_nxt_s = REQ;
               if (redir_s) begin
                  pc_nxt_s      = redir_pc_s;
                  discard_nxt_s = 1'b0;
               end else if (discard_r) begin
                  discard_nxt_s = 1'b0;
               end else begin
                  push_s   = 1'b1;
                  pc_nxt_s = next_pc(pc_r);
               end
            end else if (redir_s) begin
               state_nxt_s   = WAIT;
               discard_nxt_s = 1'b1;
               pc_nxt_s      = redir_pc_s;
            end else begin
               state_nxt_s = WAIT;
            end
         end
         default: begin
            state_nxt_s = REQ;
         end
      endcase
   end

   // FSM state register.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r <= REQ;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // PC and reply-discard tracking.
   always_ff @(posedge clk) begin
      if (reset) begin
         pc_r      <= RESET_PC;
         discard_r <= 1'b0;
`ifdef IF_ADEF_CHK_EN
         adef_done_r <= 1'b0;
`endif
      end else begin
         pc_r      <= pc_nxt_s;
         discard_r <= discard_nxt_s;
`ifdef IF_ADEF_CHK_EN
         adef_done_r <= adef_done_nxt_s;
`endif
      end
   end

   if_fetch_buf #(
      .DEPTH (BUF_DEPTH)
   ) u_fetch_buf (
      .clk        (clk),
      .reset      (reset),
      .clear      (redir_s),
      .push       (push_s),
      .push_entry (push_entry_s),
      .pop        (right_fire_s),
      .head       (head_s),
      .full       (full_s),
      .empty      (empty_s)
   );

endmodule

// File: tb/tb_if_fetch_stage.sv
// Directed self-checking bench for if_fetch_stage with a behavioural inst RAM.
// Build with +define+IF_ADEF_CHK_EN to exercise the misaligned-fetch exception path.
module tb_if_fetch_stage;

   logic        clk;
   logic        reset;
   logic        inst_req;
   logic [31:0] inst_addr;
   logic        inst_addr_ok;
   logic        inst_data_ok;
   logic [31:0] inst_rdata;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        flush;
   logic        right_valid;
   logic        right_ready;
   logic [31:0] PC;
   logic [31:0] Inst;
   logic        excp_adef;

   int          n_cmp = 0;
   int          n_err = 0;
   int          ram_delay = 1;
   logic [31:0] q_pc [$];
   logic [31:0] q_inst [$];
   logic        q_adef [$];

   localparam logic [31:0] BASE = 32'h1c00_0000;

   if_fetch_stage dut (
      .clk            (clk),
      .reset          (reset),
      .inst_req       (inst_req),
      .inst_addr      (inst_addr),
      .inst_addr_ok   (inst_addr_ok),
      .inst_data_ok   (inst_data_ok),
      .inst_rdata     (inst_rdata),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .flush          (flush),
      .right_valid    (right_valid),
      .right_ready    (right_ready),
      .PC             (PC),
      .Inst           (Inst),
      .excp_adef      (excp_adef)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic logic [31:0] ram_word(input logic [31:0] a);
      return a ^ 32'h5A5A_F00F;
   endfunction

   function automatic logic [31:0] qpc(input int i);
      return (i < q_pc.size()) ? q_pc[i] : 32'hDEAD_DEAD;
   endfunction

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_cmp++;
      if (obs !== expv) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, obs, expv);
      end
   endtask

   task automatic wait_q(input int n, input int budget, input string tag);
      int k;
      k = 0;
      while (q_pc.size() < n && k < budget) begin
         @(negedge clk);
         #2;
         k++;
      end
      if (q_pc.size() < n) check_eq(tag, 32'(q_pc.size()), 32'(n));
   endtask

   // Inst RAM: one outstanding request, reply ram_delay cycles after acceptance.
   initial begin
      logic        pend;
      int          cnt;
      logic [31:0] pend_addr;
      pend = 1'b0;
      cnt = 0;
      pend_addr = 32'h0;
      inst_data_ok = 1'b0;
      inst_rdata = 32'h0;
      forever begin
         @(negedge clk);
         inst_data_ok = 1'b0;
         if (pend) begin
            if (cnt <= 1) begin
               inst_data_ok = 1'b1;
               inst_rdata   = ram_word(pend_addr);
               pend         = 1'b0;
            end else begin
               cnt = cnt - 1;
            end
         end
         #1;
         if (reset) begin
            pend = 1'b0;
         end else if (inst_req && inst_addr_ok) begin
            pend      = 1'b1;
            cnt       = ram_delay;
            pend_addr = inst_addr;
         end
      end
   end

   // Delivery monitor: records every decode handshake.
   initial begin
      forever begin
         @(negedge clk);
         #1;
         if (right_valid && right_ready) begin
            q_pc.push_back(PC);
            q_inst.push_back(Inst);
            q_adef.push_back(excp_adef);
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int          n0;
      int          n4;
      int          k;
      logic [31:0] exp_head;
      logic        got_addr;
      logic [31:0] first_addr;

      reset = 1'b1;
      inst_addr_ok = 1'b1;
      right_ready = 1'b1;
      redirect_valid = 1'b0;
      redirect_pc = 32'h0;
      flush = 1'b0;

      // reset state
      @(negedge clk);
      #2;
      check_eq("rst_inst_req", 32'(inst_req), 32'd0);
      check_eq("rst_right_valid", 32'(right_valid), 32'd0);
      check_eq("rst_pc", PC, 32'h0);
      check_eq("rst_inst", Inst, 32'h0);
      check_eq("rst_adef", 32'(excp_adef), 32'd0);

      // test 1: first fetch latency and in-order stream
      @(negedge clk);
      reset = 1'b0;
      #2;
      check_eq("t1_first_req", 32'(inst_req), 32'd1);
      check_eq("t1_first_addr", inst_addr, BASE);
      @(negedge clk);
      #2;
      check_eq("t1_rv_early", 32'(right_valid), 32'd0);
      @(negedge clk);
      #2;
      check_eq("t1_rv", 32'(right_valid), 32'd1);
      check_eq("t1_pc", PC, BASE);
      check_eq("t1_inst", Inst, ram_word(BASE));
      wait_q(3, 20, "t1_timeout");
      check_eq("t1_q0", qpc(0), 32'h1c00_0000);
      check_eq("t1_q1", qpc(1), 32'h1c00_0004);
      check_eq("t1_q2", qpc(2), 32'h1c00_0008);

      // test 2: decode stall fills exactly BUF_DEPTH entries
      @(negedge clk);
      right_ready = 1'b0;
      #2;
      n0 = q_pc.size();
      repeat (10) @(negedge clk);
      #2;
      check_eq("t2_req_when_full", 32'(inst_req), 32'd0);
      check_eq("t2_rv_stalled", 32'(right_valid), 32'd1);
      check_eq("t2_head_stalled", PC, BASE + 32'(4 * n0));
      @(negedge clk);
      right_ready = 1'b1;
      #2;
      check_eq("t2_head0", PC, BASE + 32'(4 * n0));
      @(negedge clk);
      #2;
      check_eq("t2_rv1", 32'(right_valid), 32'd1);
      check_eq("t2_head1", PC, BASE + 32'(4 * (n0 + 1)));
      @(negedge clk);
      #2;
      check_eq("t2_only_two", 32'(right_valid), 32'd0);
      wait_q(n0 + 3, 20, "t2_timeout");
      check_eq("t2_q_next", qpc(n0 + 2), BASE + 32'(4 * (n0 + 2)));

      // test 3: redirect while waiting for data
      ram_delay = 3;
      k = 0;
      do begin
         @(negedge clk);
         #2;
         k++;
      end while (!inst_req && k < 20);
      check_eq("t3_req_seen", 32'(inst_req), 32'd1);
      @(negedge clk);
      redirect_valid = 1'b1;
      redirect_pc = 32'h1c00_0100;
      @(negedge clk);
      redirect_valid = 1'b0;
      #2;
      check_eq("t3_rv_after", 32'(right_valid), 32'd0);
      n0 = q_pc.size();
      wait_q(n0 + 2, 40, "t3_timeout");
      check_eq("t3_q0", qpc(n0), 32'h1c00_0100);
      check_eq("t3_q0_inst", (n0 < q_inst.size()) ? q_inst[n0] : 32'hDEAD_DEAD, ram_word(32'h1c00_0100));
      check_eq("t3_q1", qpc(n0 + 1), 32'h1c00_0104);
      ram_delay = 1;

      // test 4: redirect in the same cycle as data_ok
      k = 0;
      do begin
         @(negedge clk);
         #2;
         k++;
      end while (!inst_data_ok && k < 20);
      check_eq("t4_dok_seen", 32'(inst_data_ok), 32'd1);
      redirect_valid = 1'b1;
      redirect_pc = 32'h1c00_0200;
      @(negedge clk);
      redirect_valid = 1'b0;
      #2;
      check_eq("t4_req", 32'(inst_req), 32'd1);
      check_eq("t4_addr", inst_addr, 32'h1c00_0200);
      check_eq("t4_rv", 32'(right_valid), 32'd0);
      n4 = q_pc.size();
      wait_q(n4 + 2, 20, "t4_timeout");
      check_eq("t4_q0", qpc(n4), 32'h1c00_0200);
      check_eq("t4_q1", qpc(n4 + 1), 32'h1c00_0204);

      // test 5: flush with a full buffer and decode ready
      @(negedge clk);
      right_ready = 1'b0;
      #2;
      n0 = q_pc.size();
      exp_head = 32'h1c00_0200 + 32'(4 * (n0 - n4));
      repeat (8) @(negedge clk);
      right_ready = 1'b1;
      flush = 1'b1;
      redirect_pc = 32'h1c00_0300;
      #2;
      check_eq("t5_head", PC, exp_head);
      check_eq("t5_req_full", 32'(inst_req), 32'd0);
      @(negedge clk);
      flush = 1'b0;
      #2;
      check_eq("t5_rv_after", 32'(right_valid), 32'd0);
      n0 = q_pc.size();
      check_eq("t5_popped", qpc(n0 - 1), exp_head);
      wait_q(n0 + 1, 20, "t5_timeout");
      check_eq("t5_q0", qpc(n0), 32'h1c00_0300);

      // test 6: misaligned redirect target
      @(negedge clk);
      redirect_valid = 1'b1;
      redirect_pc = 32'h1c00_0102;
      @(negedge clk);
      redirect_valid = 1'b0;
      #2;
      got_addr = 1'b0;
      first_addr = 32'h0;
      k = 0;
      while (!right_valid && k < 20) begin
         if (inst_req && !got_addr) begin
            got_addr = 1'b1;
            first_addr = inst_addr;
         end
         @(negedge clk);
         #2;
         k++;
      end
`ifdef IF_ADEF_CHK_EN
      check_eq("t6_no_req", 32'(got_addr), 32'd0);
      check_eq("t6_rv", 32'(right_valid), 32'd1);
      check_eq("t6_pc", PC, 32'h1c00_0102);
      check_eq("t6_inst", Inst, 32'h0);
      check_eq("t6_adef", 32'(excp_adef), 32'd1);
      repeat (3) @(negedge clk);
      #2;
      check_eq("t6_stall_req", 32'(inst_req), 32'd0);
      check_eq("t6_stall_rv", 32'(right_valid), 32'd0);
      @(negedge clk);
      redirect_valid = 1'b1;
      redirect_pc = 32'h1c00_0400;
      @(negedge clk);
      redirect_valid = 1'b0;
      #2;
      n0 = q_pc.size();
      wait_q(n0 + 1, 20, "t6_resume_timeout");
      check_eq("t6_resume_pc", qpc(n0), 32'h1c00_0400);
      check_eq("t6_resume_adef", (n0 < q_adef.size()) ? 32'(q_adef[n0]) : 32'd9, 32'd0);
`else
      check_eq("t6_req_seen", 32'(got_addr), 32'd1);
      check_eq("t6_addr", first_addr, 32'h1c00_0100);
      check_eq("t6_rv", 32'(right_valid), 32'd1);
      check_eq("t6_pc", PC, 32'h1c00_0100);
      check_eq("t6_adef", 32'(excp_adef), 32'd0);
`endif

      // test 7: PC wraps past the top of the address space
      @(negedge clk);
      redirect_valid = 1'b1;
      redirect_pc = 32'hFFFF_FFFC;
      @(negedge clk);
      redirect_valid = 1'b0;
      #2;
      n0 = q_pc.size();
      wait_q(n0 + 2, 20, "t7_timeout");
      check_eq("t7_top", qpc(n0), 32'hFFFF_FFFC);
      check_eq("t7_wrap", qpc(n0 + 1), 32'h0000_0000);

      // test 8: reset while a request is outstanding
      ram_delay = 3;
      k = 0;
      do begin
         @(negedge clk);
         #2;
         k++;
      end while (!inst_req && k < 20);
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      ram_delay = 1;
      #2;
      check_eq("t8_req", 32'(inst_req), 32'd1);
      check_eq("t8_addr", inst_addr, BASE);
      check_eq("t8_rv", 32'(right_valid), 32'd0);
      @(negedge clk);
      @(negedge clk);
      #2;
      check_eq("t8_rv_first", 32'(right_valid), 32'd1);
      check_eq("t8_pc_first", PC, BASE);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
